// File: rtl/switch_debounce_pulse_if.sv
// switch_debounce_pulse_if: groups raw switch inputs with debounced levels and edge pulses
//   i_Switch  : raw asynchronous switch levels, 1 = pressed (driven by master)
//   o_Switch  : debounced level per channel (driven by slave)
//   o_Press   : one-cycle pulse on each debounced 0->1 transition (driven by slave)
//   o_Release : one-cycle pulse on each debounced 1->0 transition (driven by slave)
interface switch_debounce_pulse_if #(
  parameter int NUM_SW = 4
);
  logic [NUM_SW-1:0] i_Switch;
  logic [NUM_SW-1:0] o_Switch;
  logic [NUM_SW-1:0] o_Press;
  logic [NUM_SW-1:0] o_Release;
  modport master (output i_Switch, input o_Switch, o_Press, o_Release);
  modport slave (input i_Switch, output o_Switch, o_Press, o_Release);
endinterface

// File: rtl/switch_debounce_pulse.sv
// switch_debounce_pulse: per-channel synchronizer, stable-count debouncer and press/release pulse generator
//   i_Clk   : single clock, all state on its rising edge
//   i_Rst_L : asynchronous active-low reset, deassertion sampled by i_Clk
//   sw      : slave side of switch_debounce_pulse_if (i_Switch in; o_Switch, o_Press, o_Release out)
module switch_debounce_pulse #(
  parameter int NUM_SW         = 4,
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  switch_debounce_pulse_if.slave sw
);
  localparam int CW = $clog2(DEBOUNCE_LIMIT);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_LIMIT - 1);
  for (genvar c = 0; c < NUM_SW; c++) begin : g_ch
    logic          r_meta;
    logic          r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_switch;
    logic          r_press;
    logic          r_release;
    logic          w_diff;
    logic          w_done;
    assign w_diff = r_sync ^ r_switch;
    // The limit-th consecutive mismatch accepts the new level; the counter never wraps
    assign w_done = w_diff && (r_cnt == LAST);
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        r_meta    <= 1'b0;
        r_sync    <= 1'b0;
        r_cnt     <= '0;
        r_switch  <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_meta    <= sw.i_Switch[c];
        r_sync    <= r_meta;
        r_cnt     <= (w_diff && !w_done) ? r_cnt + 1'b1 : '0;
        r_switch  <= w_done ? r_sync : r_switch;
        // Pulses are registered alongside the level update so they align with its first cycle
        r_press   <= w_done && r_sync;
        r_release <= w_done && !r_sync;
      end
    end
    assign sw.o_Switch[c]  = r_switch;
    assign sw.o_Press[c]   = r_press;
    assign sw.o_Release[c] = r_release;
  end
endmodule

// File: tb/tb_switch_debounce_pulse.sv
// tb_switch_debounce_pulse: table vectors, corner sequences and random stimulus against a window-based model
module tb_switch_debounce_pulse;
  localparam int LIM = 4;
  typedef struct packed {
    logic       rn;
    logic [3:0] sw;
    logic [3:0] exp_sw;
    logic [3:0] exp_pr;
    logic [3:0] exp_rl;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [LIM:0] mhist [4];
  logic [3:0] mdeb, mpress, mrel;
  vec_t tbl [14];
  switch_debounce_pulse_if #(.NUM_SW(4)) swi ();
  switch_debounce_pulse #(.NUM_SW(4), .DEBOUNCE_LIMIT(LIM)) dut (
    .i_Clk(clk),
    .i_Rst_L(rst_n),
    .sw(swi)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Debounced level flips when the synchronized level seen on the last LIM edges
  // (raw samples two edges old) all disagree with it.
  task automatic model_edge(input logic [3:0] s, input logic rn);
    for (int c = 0; c < 4; c++) begin
      if (!rn) begin
        mhist[c] = '0;
        mdeb[c] = 1'b0;
        mpress[c] = 1'b0;
        mrel[c] = 1'b0;
      end else begin
        logic all_diff;
        all_diff = 1'b1;
        for (int k = 1; k <= LIM; k++)
          if (mhist[c][k] == mdeb[c]) all_diff = 1'b0;
        mpress[c] = all_diff && !mdeb[c];
        mrel[c] = all_diff && mdeb[c];
        if (all_diff) mdeb[c] = !mdeb[c];
        mhist[c] = {mhist[c][LIM-1:0], s[c]};
      end
    end
  endtask
  task automatic step(input logic [3:0] s, input logic rn);
    @(negedge clk);
    swi.i_Switch = s;
    rst_n = rn;
    @(posedge clk);
    model_edge(s, rn);
    #1;
    chk("model_switch", 32'(swi.o_Switch), 32'(mdeb));
    chk("model_press", 32'(swi.o_Press), 32'(mpress));
    chk("model_release", 32'(swi.o_Release), 32'(mrel));
  endtask
  task automatic do_reset();
    step(4'h0, 1'b0);
    step(4'h0, 1'b0);
  endtask
  initial begin
    int pcnt, pidx, hi;
    logic [3:0] cur;
    tbl[0]  = '{1'b1, 4'h1, 4'h0, 4'h0, 4'h0};
    tbl[1]  = '{1'b1, 4'h1, 4'h0, 4'h0, 4'h0};
    tbl[2]  = '{1'b1, 4'h1, 4'h0, 4'h0, 4'h0};
    tbl[3]  = '{1'b1, 4'h1, 4'h0, 4'h0, 4'h0};
    tbl[4]  = '{1'b1, 4'h1, 4'h0, 4'h0, 4'h0};
    tbl[5]  = '{1'b1, 4'h1, 4'h1, 4'h1, 4'h0};
    tbl[6]  = '{1'b1, 4'h1, 4'h1, 4'h0, 4'h0};
    tbl[7]  = '{1'b1, 4'h0, 4'h1, 4'h0, 4'h0};
    tbl[8]  = '{1'b1, 4'h0, 4'h1, 4'h0, 4'h0};
    tbl[9]  = '{1'b1, 4'h0, 4'h1, 4'h0, 4'h0};
    tbl[10] = '{1'b1, 4'h0, 4'h1, 4'h0, 4'h0};
    tbl[11] = '{1'b1, 4'h0, 4'h1, 4'h0, 4'h0};
    tbl[12] = '{1'b1, 4'h0, 4'h0, 4'h0, 4'h1};
    tbl[13] = '{1'b1, 4'h0, 4'h0, 4'h0, 4'h0};
    swi.i_Switch = 4'h0;
    do_reset();
    chk("reset_switch", 32'(swi.o_Switch), 32'h0);
    chk("reset_press", 32'(swi.o_Press), 32'h0);
    chk("reset_release", 32'(swi.o_Release), 32'h0);
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].sw, tbl[i].rn);
      chk($sformatf("tbl%0d_switch", i), 32'(swi.o_Switch), 32'(tbl[i].exp_sw));
      chk($sformatf("tbl%0d_press", i), 32'(swi.o_Press), 32'(tbl[i].exp_pr));
      chk($sformatf("tbl%0d_release", i), 32'(swi.o_Release), 32'(tbl[i].exp_rl));
    end
    do_reset();
    pcnt = 0;
    pidx = -1;
    step(4'h2, 1'b1);
    pcnt += int'(swi.o_Press[1]);
    step(4'h0, 1'b1);
    pcnt += int'(swi.o_Press[1]);
    step(4'h2, 1'b1);
    pcnt += int'(swi.o_Press[1]);
    step(4'h0, 1'b1);
    pcnt += int'(swi.o_Press[1]);
    for (int i = 0; i < 20; i++) begin
      step(4'h2, 1'b1);
      if (swi.o_Press[1]) begin
        pcnt++;
        if (pidx < 0) pidx = i;
      end
    end
    chk("bounce_press_count", 32'(pcnt), 32'd1);
    chk("bounce_press_clock", 32'(pidx + 1), 32'd6);
    do_reset();
    hi = 0;
    for (int i = 0; i < 13; i++) begin
      step(i < 3 ? 4'h4 : 4'h0, 1'b1);
      hi += int'(swi.o_Switch[2]) + int'(swi.o_Press[2]);
    end
    chk("glitch_no_output", 32'(hi), 32'd0);
    do_reset();
    step(4'h8, 1'b1);
    step(4'h8, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_async_out", 32'({swi.o_Switch, swi.o_Press, swi.o_Release}), 32'h0);
    step(4'h8, 1'b0);
    pcnt = 0;
    pidx = -1;
    for (int i = 0; i < 12; i++) begin
      step(4'h8, 1'b1);
      if (swi.o_Press[3]) begin
        pcnt++;
        if (pidx < 0) pidx = i;
      end
    end
    chk("midreset_press_count", 32'(pcnt), 32'd1);
    chk("midreset_press_clock", 32'(pidx + 1), 32'd6);
    do_reset();
    pcnt = 0;
    for (int i = 0; i < 106; i++) begin
      step(4'hF, 1'b1);
      if (i == 5) chk("all_press_vec", 32'(swi.o_Press), 32'hF);
      if (swi.o_Press != 4'h0) pcnt++;
    end
    chk("all_press_once", 32'(pcnt), 32'd1);
    chk("all_switch_held", 32'(swi.o_Switch), 32'hF);
    cur = 4'h0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 4; c++)
        if ($urandom_range(0, 7) == 0) cur[c] = ~cur[c];
      step(cur, $urandom_range(0, 199) != 0);
      chk("rand_exclusive", 32'(swi.o_Press & swi.o_Release), 32'h0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/switch_debounce_pulse.md
SWITCH_DEBOUNCE_PULSE -- requirements
Module: switch_debounce_pulse

Interface
REQ-001 SHALL have parameter NUM_SW, default 4: number of independent switch channels.
REQ-002 SHALL have parameter DEBOUNCE_LIMIT, default 250000: stable-cycle count before acceptance (10 ms at 25 MHz); legal range 2 to 2^24.
REQ-003 SHALL have port i_Clk, input, 1: single clock; all state on its rising edge.
REQ-004 SHALL have port i_Rst_L, input, 1: reset, asynchronous and active-low; assertion is async, deassertion is sampled by i_Clk.
REQ-005 SHALL have port i_Switch, input, NUM_SW: raw asynchronous switch levels, 1 = pressed.
REQ-006 SHALL have port o_Switch, output, NUM_SW: debounced level per channel.
REQ-007 SHALL have port o_Press, output, NUM_SW: one-cycle pulse on each debounced 0->1 transition; drives the increment inputs of the downstream display units.
REQ-008 SHALL have port o_Release, output, NUM_SW: one-cycle pulse on each debounced 1->0 transition.

Function
REQ-009 SHALL give each channel an independent, identical path with no cross-channel coupling.
REQ-010 SHALL pass each i_Switch bit through a two-flop synchronizer; only the second flop output (sync) feeds later logic.
REQ-011 SHALL keep one counter per channel of width clog2(DEBOUNCE_LIMIT), no wrap.
REQ-012 SHALL, per channel per edge, follow exactly one rule: sync == o_Switch -> counter 0; sync != o_Switch and counter < DEBOUNCE_LIMIT-1 -> counter +1; sync != o_Switch and counter == DEBOUNCE_LIMIT-1 -> o_Switch <= sync, counter 0.
REQ-013 SHALL update o_Switch on the DEBOUNCE_LIMIT-th consecutive edge where sync differs from o_Switch; total latency from a clean raw edge is DEBOUNCE_LIMIT+2 clocks.
REQ-014 SHALL clear the counter on any sync glitch back to the o_Switch level before the limit, leaving o_Switch unchanged; the next mismatch restarts from 1.
REQ-015 SHALL register o_Press high for exactly the cycle in which o_Switch first reads 1 after a 0->1 update, low otherwise.
REQ-016 SHALL register o_Release high for exactly the cycle in which o_Switch first reads 0 after a 1->0 update, low otherwise.
REQ-017 SHALL never assert o_Press and o_Release together on one channel; pulses of different channels may coincide.
REQ-018 SHALL make every output a direct flop output, with no combinational path from i_Switch.
REQ-019 SHALL make a held switch produce a single o_Press regardless of hold duration.

Reset
REQ-020 SHALL, while i_Rst_L is 0, force synchronizer flops, counters, o_Switch, o_Press and o_Release to 0.
REQ-021 SHALL, on mid-debounce reset, discard the count; after release a still-pressed switch needs a full DEBOUNCE_LIMIT+2 clocks and then produces one o_Press.
REQ-022 SHALL emit no o_Press or o_Release in the first cycle after deassertion unless REQ-012 qualifies it.

Verification (DEBOUNCE_LIMIT = 4, NUM_SW = 4)
REQ-023 SHALL cover clean press: i_Switch[0] 0->1 held -> o_Switch[0]=1 exactly 6 clocks later, o_Press[0]=1 that cycle only, other channels remain 0.
REQ-024 SHALL cover bounce: i_Switch[1] toggles 1,0,1,0 on consecutive clocks then holds 1 -> one o_Press[1], 6 clocks after the final rise, with no earlier pulse.
REQ-025 SHALL cover release: after ch0 is debounced high, i_Switch[0] 1->0 -> o_Switch[0]=0 and o_Release[0]=1 for one cycle 6 clocks later, with no o_Press.
REQ-026 SHALL cover a short glitch: i_Switch[2] high for 3 clocks then low -> o_Switch[2] and o_Press[2] stay 0 throughout.
REQ-027 SHALL cover reset mid-count: i_Switch[3] high, i_Rst_L low for 1 clock at clock 3 -> outputs 0 at once; o_Press[3] occurs 6 clocks after release.
REQ-028 SHALL cover simultaneous and held inputs: all four switches rise together -> o_Press = 4'b1111 for one cycle; holding 100 clocks gives no further pulses.
